gate_exerciser: RTL
===================

Name: gate_exerciser

Overview:
- Self-checking stimulus/response engine that sits on the other side of our transistor-level gate cells.
- Drives every input combination onto a gate's inputs, waits a programmable settle time, then samples the gate output.
- Compares each sample against an expected truth table and reports per-vector failures, an error count and a pass flag.
- Used in benches and on-board self-test to qualify gate cells (AND, NAND, OR, ...) built from pmos/nmos primitives.

Parameters:
- N_IN, 2, number of gate inputs driven; legal range 1..4.
- SETTLE, 2, settle cycles after applying a vector before sampling; legal range 1..15.
- TRUTH, 4'b1000, expected gate output. Width 2**N_IN. Bit k is the expected output when the input vector equals k, with input bit 0 as dut_in[0]. The default is 2-input AND.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled request to run a full sweep; honoured only in IDLE.
- dut_in  output  N_IN  registered input vector driven to the gate under test.
- dut_out  input  1  gate output being checked; same clock domain, no synchroniser.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  1 when the last completed sweep had zero mismatches; held until the next start.
- fail_vec  output  2**N_IN  bit k set when vector k mismatched in the last sweep.
- err_count  output  N_IN+1  number of mismatching vectors in the last sweep.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low.
- Reset values: dut_in=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0, state=IDLE, vector index=0, settle counter=0.
- States:
  - IDLE: busy=0, dut_in=0.
  - APPLY: busy=1, dut_in=current vector index.
  - IDLE -> APPLY: start=1 at edge E0. At E0, the block sets busy=1, vector index=0, settle counter=0, and clears pass, fail_vec and err_count.
- Vector timing (S = SETTLE):
  - Vector k is driven from edge E0+k*(S+1) to edge E0+(k+1)*(S+1).
  - dut_out is sampled at edge E0+(k+1)*(S+1).
  - At that same edge, dut_in advances to k+1.
  - Each vector is therefore held S+1 cycles.
- Compare: mismatch when dut_out != TRUTH[k]. On mismatch, set fail_vec[k] and increment err_count. The increment cannot overflow, because the maximum is 2**N_IN.
- Completion:
  - After the sample of vector 2**N_IN-1, at edge E0+2**N_IN*(S+1), the state returns to IDLE.
  - At that edge: busy=0, dut_in=0, done=1 for exactly one cycle.
  - pass = (no mismatch in the whole sweep, including the final sample). It is computed from the final-sample result, not a stale fail_vec.
- Total sweep latency is 2**N_IN*(S+1) cycles. With the defaults this is 12 cycles.
- start while busy: ignored, with no restart and no effect on results.
- start held high continuously: a new sweep begins at the edge after the done pulse. Results then clear as for any start.
- Reset mid-sweep: everything returns to reset values immediately. There is no done pulse and no partial result.
- Vector index wrap is not used; the sweep stops at 2**N_IN-1.
- dut_out changing during settle cycles has no effect; only the sample edge matters.
- Synthesizable; no latches; no combinational path from dut_out to any output.

Test Plan:
- Defaults with a correct CMOS AND model; pulse start at E0 -> dut_in steps 0,1,2,3 every 3 cycles. done pulses after edge E0+12 with pass=1, fail_vec=4'b0000, err_count=0.
- Defaults with dut_out stuck at 0 -> fail_vec=4'b1000, err_count=1, pass=0. With dut_out stuck at 1 -> fail_vec=4'b0111, err_count=3, pass=0.
- Defaults with a NAND model -> fail_vec=4'b1111, err_count=4, pass=0. Repeat with TRUTH=4'b0111 -> pass=1.
- Assert start again at E0+4 and E0+8 during a sweep -> no change to dut_in sequence; a single done at E0+12.
- Drop rst_n at E0+7 (during vector 2) -> dut_in=0, busy=0, outputs zero that cycle, no done. A fresh start then gives the correct result in 12 cycles.
- N_IN=3, SETTLE=1, TRUTH=8'b1000_0000, start held high -> done every 17 cycles (16-cycle sweep + 1 IDLE edge); pass=1 against a 3-input AND model.

Source files
------------

// File: rtl/gate_exerciser_if.sv
// Control/status and gate-side signals of the gate exerciser.
// The slave modport is the exerciser; the master modport is its host and gate model.
interface gate_exerciser_if #(
    parameter int unsigned N_IN = 2
);
    logic                   start;
    logic                   dut_out;
    logic [N_IN-1:0]        dut_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [(2**N_IN)-1:0]   fail_vec;
    logic [N_IN:0]          err_count;

    modport slave (
        input  start,
        input  dut_out,
        output dut_in,
        output busy,
        output done,
        output pass,
        output fail_vec,
        output err_count
    );

    modport master (
        output start,
        output dut_out,
        input  dut_in,
        input  busy,
        input  done,
        input  pass,
        input  fail_vec,
        input  err_count
    );
endinterface

// File: rtl/gate_exerciser.sv
// Sweeps every input vector onto a gate cell, samples its output after a settle
// time and checks it against an expected truth table.
module gate_exerciser #(
    parameter int unsigned          N_IN   = 2,
    parameter int unsigned          SETTLE = 2,
    parameter logic [(2**N_IN)-1:0] TRUTH  = 4'b1000
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_exerciser_if.slave  bus
);
    localparam int unsigned NV = 2**N_IN;
    localparam int unsigned IW = N_IN;
    localparam int unsigned EW = N_IN + 1;
    localparam int unsigned CW = 4;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_APPLY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] dut_in_q, dut_in_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [NV-1:0] fail_q, fail_d;
    logic [EW-1:0] err_q, err_d;
    logic          mismatch_c;

    // Only meaningful on the sample edge; the FSM ignores it otherwise.
    assign mismatch_c = (bus.dut_out != TRUTH[idx_q]);

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_APPLY;
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    cnt_d    = '0;
                    dut_in_d = '0;
                    pass_d   = 1'b0;
                    fail_d   = '0;
                    err_d    = '0;
                end
            end
            S_APPLY: begin
                if (cnt_q == CW'(SETTLE)) begin
                    cnt_d = '0;
                    if (mismatch_c) begin
                        fail_d[idx_q] = 1'b1;
                        err_d         = err_q + EW'(1);
                    end
                    if (idx_q == IW'(NV - 1)) begin
                        // Pass uses this edge's sample directly, not the registered history alone.
                        state_d  = S_IDLE;
                        busy_d   = 1'b0;
                        dut_in_d = '0;
                        idx_d    = '0;
                        done_d   = 1'b1;
                        pass_d   = (err_q == '0) && !mismatch_c;
                    end else begin
                        idx_d    = idx_q + IW'(1);
                        dut_in_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                dut_in_d = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_vec  = fail_q;
    assign bus.err_count = err_q;

endmodule
